// File: rtl/chunked_alu_if.sv
// Execute-stage <-> chunked ALU start/done bus.
// Carries cf only when CHUNKED_ALU_CF_EN is defined.
interface chunked_alu_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic [1:0]       ifun;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [2:0]       cc;
`ifdef CHUNKED_ALU_CF_EN
  logic             cf;

  modport master (
    output start, ifun, a, b,
    input  busy, done, result, cc, cf
  );

  modport slave (
    input  start, ifun, a, b,
    output busy, done, result, cc, cf
  );
`else
  modport master (
    output start, ifun, a, b,
    input  busy, done, result, cc
  );

  modport slave (
    input  start, ifun, a, b,
    output busy, done, result, cc
  );
`endif
endinterface

// File: rtl/chunked_alu.sv
// Multi-cycle Y86-64 OPq ALU, CHUNK bits per clock, ZF/SF/OF codes.
// CHUNKED_ALU_CF_EN adds a registered carry/borrow flag output.
module chunked_alu #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  chunked_alu_if.slave  bus
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCH - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [1:0] F_ADD = 2'd0;
  localparam logic [1:0] F_SUB = 2'd1;
  localparam logic [1:0] F_AND = 2'd2;
  localparam logic [1:0] F_XOR = 2'd3;

  logic [0:0]       state_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, acc_d;
  logic [WIDTH-1:0] result_q;
  logic [1:0]       fn_q;
  logic [IW-1:0]    idx_q;
  logic             c_q, z_q, done_q;
  logic [2:0]       cc_q, cc_d;

  logic [CHUNK-1:0] sa, sb, ob, sl;
  logic [CHUNK:0]   sum;
  logic             co, last, of_d;

  always_comb begin
    sa    = a_q[idx_q*CHUNK +: CHUNK];
    sb    = b_q[idx_q*CHUNK +: CHUNK];
    ob    = (fn_q == F_SUB) ? ~sa : sa;
    sum   = {1'b0, sb} + {1'b0, ob}
          + {{CHUNK{1'b0}}, c_q};
    co    = sum[CHUNK];
    sl    = sum[CHUNK-1:0];
    unique case (1'b1)
      fn_q == F_AND: sl = sb & sa;
      fn_q == F_XOR: sl = sb ^ sa;
      default:       sl = sum[CHUNK-1:0];
    endcase
    acc_d = acc_q;
    acc_d[idx_q*CHUNK +: CHUNK] = sl;
    last  = (idx_q == LAST);
    of_d  = 1'b0;
    unique case (1'b1)
      fn_q == F_ADD:
        of_d = (a_q[WIDTH-1] == b_q[WIDTH-1])
            && (acc_d[WIDTH-1] != a_q[WIDTH-1]);
      fn_q == F_SUB:
        of_d = (a_q[WIDTH-1] != b_q[WIDTH-1])
            && (acc_d[WIDTH-1] != b_q[WIDTH-1]);
      default: of_d = 1'b0;
    endcase
    cc_d = {of_d, acc_d[WIDTH-1], ~(z_q | (|sl))};
  end

`ifdef CHUNKED_ALU_CF_EN
  logic cf_q;
  // Borrow for sub is the complement of the two's-complement carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cf_q <= 1'b0;
    end else if (state_q == RUN && last) begin
      unique case (1'b1)
        fn_q == F_ADD: cf_q <= co;
        fn_q == F_SUB: cf_q <= ~co;
        default:       cf_q <= 1'b0;
      endcase
    end
  end
  assign bus.cf = cf_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      fn_q     <= '0;
      idx_q    <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
      cc_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            fn_q    <= bus.ifun;
            idx_q   <= '0;
            c_q     <= (bus.ifun == F_SUB);
            z_q     <= 1'b0;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          c_q   <= co;
          z_q   <= z_q | (|sl);
          idx_q <= idx_q + IW'(1);
          if (last) begin
            state_q  <= IDLE;
            result_q <= acc_d;
            cc_q     <= cc_d;
            done_q   <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy   = (state_q == RUN);
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.cc     = cc_q;
endmodule

// File: tb/tb_chunked_alu.sv
// Directed-vector bench for chunked_alu, WIDTH=64, CHUNK=16.
// Define CHUNKED_ALU_CF_EN to also check the carry flag.
module tb_chunked_alu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  chunked_alu_if #(.WIDTH(64)) bus ();

  chunked_alu #(.WIDTH(64), .CHUNK(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus.done && n < 12);
  endtask

  task automatic launch(input logic [1:0] f,
                        input logic [63:0] va,
                        input logic [63:0] vb);
    @(negedge clk);
    bus.ifun  = f;
    bus.a     = va;
    bus.b     = vb;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic run_op(input string tag,
                        input logic [1:0] f,
                        input logic [63:0] va,
                        input logic [63:0] vb,
                        input logic [63:0] er,
                        input logic [2:0] ecc,
                        input logic ecf);
    int n;
    launch(f, va, vb);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
    wait_done(n);
    chk({tag, "_lat"}, 64'(n), 64'd4);
    chk({tag, "_res"}, bus.result, er);
    chk({tag, "_cc"}, 64'(bus.cc), 64'(ecc));
`ifdef CHUNKED_ALU_CF_EN
    chk({tag, "_cf"}, 64'(bus.cf), 64'(ecf));
`else
    if (ecf === 1'bx) $display("unused");
`endif
  endtask

  initial begin
    int n, dn;
    bus.start = 1'b0;
    bus.ifun  = 2'd0;
    bus.a     = '0;
    bus.b     = '0;
    #2;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_res", bus.result, 64'd0);
    chk("rst_cc", 64'(bus.cc), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add_ovf", 2'd0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, 3'b110, 1'b0);
    run_op("add_ripple", 2'd0, 64'd1, 64'h0000_0000_FFFF_FFFF,
           64'h0000_0001_0000_0000, 3'b000, 1'b0);
    run_op("add_wrap", 2'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF,
           64'd0, 3'b001, 1'b1);
    run_op("sub_eq", 2'd1, 64'd5, 64'd5,
           64'd0, 3'b001, 1'b0);
    run_op("sub_ovf", 2'd1, 64'd1, 64'h8000_0000_0000_0000,
           64'h7FFF_FFFF_FFFF_FFFF, 3'b100, 1'b0);
    run_op("and", 2'd2, 64'h0F0F_0F0F_0F0F_0F0F,
           64'hF0F0_F0F0_F0F0_F0F0, 64'd0, 3'b001, 1'b0);
    run_op("xor", 2'd3, 64'h0F0F_0F0F_0F0F_0F0F,
           64'hF0F0_F0F0_F0F0_F0F0,
           64'hFFFF_FFFF_FFFF_FFFF, 3'b010, 1'b0);

    // Start pulses during RUN cycles 1 and 2 must be ignored.
    launch(2'd0, 64'd2, 64'd3);
    @(negedge clk);
    bus.a     = 64'd100;
    bus.b     = 64'd200;
    bus.start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    dn = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) dn++;
    end
    chk("ign_dones", 64'(dn), 64'd1);
    chk("ign_res", bus.result, 64'd5);
    chk("ign_busy", 64'(bus.busy), 64'd0);

    // Back-to-back: start held in the done cycle.
    launch(2'd0, 64'd2, 64'd3);
    wait_done(n);
    chk("b2b_lat1", 64'(n), 64'd4);
    chk("b2b_res1", bus.result, 64'd5);
    bus.ifun  = 2'd1;
    bus.a     = 64'd10;
    bus.b     = 64'd4;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("b2b_busy", 64'(bus.busy), 64'd1);
    chk("b2b_hold", bus.result, 64'd5);
    wait_done(n);
    chk("b2b_lat2", 64'(n), 64'd4);
    chk("b2b_res2", bus.result, 64'hFFFF_FFFF_FFFF_FFFA);
    chk("b2b_cc2", 64'(bus.cc), 64'(3'b010));
    repeat (3) @(posedge clk);
    #1;
    chk("stable_res", bus.result, 64'hFFFF_FFFF_FFFF_FFFA);
    chk("stable_cc", 64'(bus.cc), 64'(3'b010));
    chk("stable_done", 64'(bus.done), 64'd0);

    // Asynchronous reset in the third RUN cycle.
    launch(2'd0, 64'd7, 64'd8);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(bus.busy), 64'd0);
    chk("arst_done", 64'(bus.done), 64'd0);
    chk("arst_res", bus.result, 64'd0);
    chk("arst_cc", 64'(bus.cc), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) dn++;
    end
    chk("arst_nodone", 64'(dn), 64'd0);
    run_op("post_rst", 2'd0, 64'd7, 64'd8,
           64'd15, 3'b000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/chunked_alu.md
# chunked_alu

Multi-cycle, width-parametrised integer ALU for the execute stage. It evaluates Y86-64 OPq functions (addq, subq, andq, xorq) one CHUNK-bit slice per clock, rippling carry through a registered carry bit, and produces ZF/SF/OF condition codes. A start/done handshake lets the execute stage trade latency for a shorter adder path.

## Interface
- WIDTH, 64, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 16, bits processed per cycle; NCH = WIDTH/CHUNK cycles per operation.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; accepted only when busy=0
- ifun  in  2  0=add (b+a), 1=sub (b−a), 2=and, 3=xor
- a  in  WIDTH  operand valA
- b  in  WIDTH  operand valB
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse when result/cc update
- result  out  WIDTH  valE, held until next completion
- cc  out  3  cc[0]=ZF, cc[1]=SF, cc[2]=OF, held until next completion

## Operation
- States: IDLE (busy=0), RUN (busy=1). No other states.
- IDLE & start=1: latch a, b, ifun into operand registers. Clear the chunk index to 0. Set carry to 1 for sub and 0 otherwise. Clear the zero accumulator. Go to RUN.
- In RUN, each cycle processes slice [idx*CHUNK +: CHUNK]:
  - add: slice sum of b and a plus carry.
  - sub: b + ~a + carry, where carry starts at 1 (two's complement).
  - and/xor: bitwise; carry is unused.
  - The slice is written into the internal result register. Carry-out is registered. The zero accumulator is ORed with the slice.
- After the slice with idx = NCH−1, update outputs and return to IDLE:
  - result = full assembled value.
  - ZF = 1 iff all result bits are 0.
  - SF = result[WIDTH−1].
  - OF for add: sign(a)==sign(b) and sign(result)!=sign(a).
  - OF for sub: sign(a)!=sign(b) and sign(result)!=sign(b).
  - OF for and/xor: 0.
- start while busy=1 is ignored. Operands and ifun may change freely after acceptance.
- Outputs result and cc change only on completion. done=1 for exactly that following cycle.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, result=0, cc=3'b000, internal registers 0. Takes effect immediately, including mid-RUN. The aborted operation never signals done.
- start sampled at edge E0 → busy=1 after E0. Slices are computed at edges E1..E_NCH.
- At E_NCH, result/cc load, done goes 1 and busy goes 0.
- Latency is NCH cycles from the accepting edge to done high. Default configuration: 4 cycles.
- Back-to-back: start high during the done cycle (busy=0) is accepted. Throughput is one operation per NCH cycles.
- NCH=1 (CHUNK=WIDTH): single-cycle RUN; done one cycle after start.

## Configuration
- CHUNKED_ALU_CF_EN defined:
  - Adds output cf (1 bit), reset 0, updated with cc.
  - cf = final carry-out for add.
  - cf = inverted final carry-out (borrow) for sub.
  - cf = 0 for and/xor.
- Not defined: port cf is absent. No carry state is exposed; only ZF/SF/OF.

## Test plan
- Add overflow, WIDTH=64, CHUNK=16: a=1, b=0x7FFF_FFFF_FFFF_FFFF, ifun=0 → done exactly 4 cycles after the accepting edge; result=0x8000_0000_0000_0000, cc: ZF=0, SF=1, OF=1.
- Inter-chunk carry: a=1, b=0x0000_0000_FFFF_FFFF, add → result=0x0000_0001_0000_0000, ZF=0, SF=0, OF=0. With CHUNKED_ALU_CF_EN: a=1, b=0xFFFF_FFFF_FFFF_FFFF → result=0, ZF=1, cf=1.
- Subtract: a=5, b=5, ifun=1 → result=0, ZF=1, SF=0, OF=0. Then a=1, b=0x8000_0000_0000_0000 → result=0x7FFF_FFFF_FFFF_FFFF, OF=1, SF=0.
- Logic ops: a=0x0F0F_0F0F_0F0F_0F0F, b=0xF0F0_F0F0_F0F0_F0F0:
  - and → result=0, ZF=1, OF=0.
  - xor → result=0xFFFF_FFFF_FFFF_FFFF, SF=1, ZF=0, OF=0.
- Handshake:
  - start pulsed on cycles 1 and 2 of a RUN → the second pulse is ignored and only one done fires.
  - start held in the done cycle → second operation accepted; its done arrives 4 cycles later.
  - Result/cc stay stable between completions.
- Reset mid-operation: drop rst_n during the third RUN cycle → busy, done, result and cc go 0 without waiting for a clock edge. No done pulse after release. The next start completes normally.
